// File: rtl/instr_fetch.sv
// Instruction fetch: reads 16-bit words over req/ack, assembles one- or two-word instructions
// and hands them to decode with a valid/ready handshake; handles redirects and HLT.
module instr_fetch #(
   parameter int unsigned     PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_VEC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req,
   output logic [PC_W-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [15:0]     mem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_opcode,
   output logic [15:0]     out_instr,
   output logic [15:0]     out_imm,
   output logic [PC_W-1:0] out_pc,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            halted
);

   typedef enum logic [1:0] {StFetch0, StFetch1, StIssue, StHalt} state_t;

   state_t          r_state, w_state_d;
   logic [PC_W-1:0] r_pc, w_pc_d;
   logic [15:0]     r_word0, w_word0_d;
   logic [15:0]     r_imm, w_imm_d;
   logic [PC_W-1:0] r_out_pc, w_out_pc_d;
   logic            r_out_valid, w_out_valid_d;
   logic            r_halted, w_halted_d;
   logic            r_kill, w_kill_d;
   logic [PC_W-1:0] r_kill_pc, w_kill_pc_d;
   logic            w_mem_req;
   logic [6:0]      w_rd_opc;
   logic            w_two_word;
   logic            w_is_hlt;

   assign w_rd_opc   = mem_rdata[15:9];
   assign w_two_word = (w_rd_opc == 7'b0101000) || (w_rd_opc[6:3] == 4'b0111) ||
                       (w_rd_opc[6:3] == 4'b1010) || (w_rd_opc[6:3] == 4'b1011);
   assign w_is_hlt   = (r_word0[15:11] == 5'b00001);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StFetch0;
         r_pc        <= RESET_VEC;
         r_word0     <= '0;
         r_imm       <= '0;
         r_out_pc    <= '0;
         r_out_valid <= 1'b0;
         r_halted    <= 1'b0;
         r_kill      <= 1'b0;
         r_kill_pc   <= '0;
      end else begin
         r_state     <= w_state_d;
         r_pc        <= w_pc_d;
         r_word0     <= w_word0_d;
         r_imm       <= w_imm_d;
         r_out_pc    <= w_out_pc_d;
         r_out_valid <= w_out_valid_d;
         r_halted    <= w_halted_d;
         r_kill      <= w_kill_d;
         r_kill_pc   <= w_kill_pc_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_pc_d        = r_pc;
      w_word0_d     = r_word0;
      w_imm_d       = r_imm;
      w_out_pc_d    = r_out_pc;
      w_out_valid_d = r_out_valid;
      w_halted_d    = r_halted;
      w_kill_d      = r_kill;
      w_kill_pc_d   = r_kill_pc;
      w_mem_req     = 1'b0;
      unique case (r_state)
         StFetch0, StFetch1: begin
            w_mem_req = 1'b1;
            if (mem_ack) begin
               if (redirect || r_kill) begin
                  // Flushed request: drop the data, the newest redirect target wins
                  w_kill_d  = 1'b0;
                  w_pc_d    = redirect ? redirect_pc : r_kill_pc;
                  w_state_d = StFetch0;
               end else if (r_state == StFetch0) begin
                  w_word0_d  = mem_rdata;
                  w_out_pc_d = r_pc;
                  w_pc_d     = r_pc + PC_W'(1);
                  if (w_two_word) begin
                     w_state_d = StFetch1;
                  end else begin
                     w_imm_d       = '0;
                     w_out_valid_d = 1'b1;
                     w_state_d     = StIssue;
                  end
               end else begin
                  w_imm_d       = mem_rdata;
                  w_pc_d        = r_pc + PC_W'(1);
                  w_out_valid_d = 1'b1;
                  w_state_d     = StIssue;
               end
            end else if (redirect) begin
               // Request in flight cannot be withdrawn; remember where to go once it returns
               w_kill_d    = 1'b1;
               w_kill_pc_d = redirect_pc;
            end
         end
         StIssue: begin
            if (redirect) begin
               w_out_valid_d = 1'b0;
               w_halted_d    = 1'b0;
               w_pc_d        = redirect_pc;
               w_state_d     = StFetch0;
            end else if (out_ready) begin
               w_out_valid_d = 1'b0;
               if (w_is_hlt) begin
                  w_halted_d = 1'b1;
                  w_state_d  = StHalt;
               end else begin
                  w_state_d = StFetch0;
               end
            end
         end
         StHalt: begin
            if (redirect) begin
               w_out_valid_d = 1'b0;
               w_halted_d    = 1'b0;
               w_pc_d        = redirect_pc;
               w_state_d     = StFetch0;
            end
         end
         default: w_state_d = StFetch0;
      endcase
   end

   assign mem_req    = w_mem_req & ~rst;
   assign mem_addr   = r_pc;
   assign out_valid  = r_out_valid;
   assign out_opcode = r_word0[15:9];
   assign out_instr  = r_word0;
   assign out_imm    = r_imm;
   assign out_pc     = r_out_pc;
   assign halted     = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run against a program-order model.
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_opcode;
   logic [15:0] out_instr;
   logic [15:0] out_imm;
   logic [31:0] out_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halted;

   int n_tests = 0;
   int n_fail  = 0;
   int lat_min = 1;
   int lat_max = 1;
   bit [15:0] mem [bit [31:0]];

   instr_fetch #(.PC_W(32), .RESET_VEC(32'h10)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_instr(out_instr), .out_imm(out_imm), .out_pc(out_pc),
      .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[15:0] ^ 16'h3C5A;
   endfunction

   // Memory: answers each request after lat_min..lat_max extra cycles, one ack per request
   initial begin
      int cnt;
      logic [31:0] a;
      cnt = -1;
      a = '0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_ack = 1'b0;
         if (rst) begin
            cnt = -1;
            continue;
         end
         if (cnt < 0 && mem_req) begin
            cnt = $urandom_range(lat_max, lat_min);
            a = mem_addr;
         end
         if (cnt >= 0) begin
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== a) begin
               n_fail++;
               $display("FAIL req_stable: req=%0b addr=%h, expected req=1 addr=%h",
                        mem_req, mem_addr, a);
            end
            if (cnt == 0) begin
               mem_ack = 1'b1;
               mem_rdata = rd(a);
               cnt = -1;
            end else begin
               cnt--;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      mem.delete();
      lat_min = 1; lat_max = 1; out_ready = 1'b1;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({mem_req, out_valid, halted} !== 3'b000 || out_pc !== 0 || out_instr !== 0 ||
          out_imm !== 0) begin
         n_fail++;
         $display("FAIL reset_state: req=%0b valid=%0b halted=%0b pc=%h instr=%h imm=%h, expected all 0",
                  mem_req, out_valid, halted, out_pc, out_instr, out_imm);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_req: req=%0b addr=%h valid=%0b, expected 1 00000010 0",
                  mem_req, mem_addr, out_valid);
      end
   endtask

   task automatic test_nop();
      mem.delete();
      mem[32'h10] = 16'h0000;
      lat_min = 1; lat_max = 1; out_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_opcode !== 7'h0 || out_pc !== 32'h10 || out_imm !== 16'h0) begin
         n_fail++;
         $display("FAIL nop_issue: valid=%0b opc=%h pc=%h imm=%h, expected 1 00 00000010 0000",
                  out_valid, out_opcode, out_pc, out_imm);
      end
      @(negedge clk);
      for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h11) begin
         n_fail++;
         $display("FAIL nop_next_addr: req=%0b addr=%h, expected 1 00000011", mem_req, mem_addr);
      end
   endtask

   task automatic test_two_word();
      int nreq;
      mem.delete();
      mem[32'h10] = 16'h7000;
      mem[32'h11] = 16'hBEEF;
      lat_min = 1; lat_max = 1; out_ready = 1'b1;
      do_reset();
      nreq = 0;
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin
         @(negedge clk);
         if (mem_ack === 1'b1) nreq++;
      end
      n_tests++;
      if (out_valid !== 1'b1 || out_opcode !== 7'h38 || out_imm !== 16'hBEEF ||
          out_instr !== 16'h7000 || out_pc !== 32'h10 || nreq != 2) begin
         n_fail++;
         $display("FAIL ldm_issue: valid=%0b opc=%h imm=%h instr=%h pc=%h acks=%0d, expected 1 38 beef 7000 00000010 2",
                  out_valid, out_opcode, out_imm, out_instr, out_pc, nreq);
      end
      @(negedge clk);
      for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
      n_tests++;
      if (mem_addr !== 32'h12) begin
         n_fail++;
         $display("FAIL ldm_next_addr: addr=%h, expected 00000012", mem_addr);
      end
   endtask

   task automatic test_stall();
      logic [15:0] s_instr;
      logic [31:0] s_pc;
      mem.delete();
      mem[32'h10] = 16'h1234;
      lat_min = 1; lat_max = 1; out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
      s_instr = out_instr;
      s_pc = out_pc;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1 || mem_req !== 1'b0 || out_instr !== 16'h1234 ||
             out_pc !== 32'h10 || out_instr !== s_instr || out_pc !== s_pc) begin
            n_fail++;
            $display("FAIL stall_hold: cycle=%0d valid=%0b req=%0b instr=%h pc=%h, expected 1 0 1234 00000010",
                     c, out_valid, mem_req, out_instr, out_pc);
         end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_cycle6: valid=%0b, expected 1", out_valid);
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h11) begin
         n_fail++;
         $display("FAIL stall_after_fire: valid=%0b req=%0b addr=%h, expected 0 1 00000011",
                  out_valid, mem_req, mem_addr);
      end
   endtask

   task automatic test_redirect_kill();
      bit stale;
      bit acked;
      mem.delete();
      mem[32'h10] = 16'h1111;
      mem[32'h40] = 16'h2222;
      lat_min = 3; lat_max = 3; out_ready = 1'b1;
      do_reset();
      @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 32'h40;
      @(posedge clk);
      #1 redirect = 1'b0;
      stale = 1'b0;
      acked = 1'b0;
      for (int i = 0; i < 10 && !acked; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) stale = 1'b1;
         if (mem_ack === 1'b1) acked = 1'b1;
      end
      @(negedge clk);
      n_tests++;
      if (!acked || mem_req !== 1'b1 || mem_addr !== 32'h40 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL kill_next_addr: acked=%0b req=%0b addr=%h valid=%0b, expected 1 1 00000040 0",
                  acked, mem_req, mem_addr, out_valid);
      end
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
      n_tests++;
      if (stale || out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 16'h2222) begin
         n_fail++;
         $display("FAIL kill_issue: stale=%0b valid=%0b pc=%h instr=%h, expected 0 1 00000040 2222",
                  stale, out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_halt();
      mem.delete();
      mem[32'h10] = 16'h0800;
      mem[32'h20] = 16'h0000;
      lat_min = 1; lat_max = 1; out_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++;
         if (halted !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_hold: cycle=%0d halted=%0b req=%0b valid=%0b, expected 1 0 0",
                     c, halted, mem_req, out_valid);
         end
      end
      @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 32'h20;
      @(posedge clk);
      #1 redirect = 1'b0;
      @(negedge clk);
      n_tests++;
      if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h20) begin
         n_fail++;
         $display("FAIL halt_redirect: halted=%0b req=%0b addr=%h, expected 0 1 00000020",
                  halted, mem_req, mem_addr);
      end
   endtask

   task automatic test_back_to_back();
      mem.delete();
      lat_min = 0; lat_max = 0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) mem[32'h10 + i] = 16'h0200;
      do_reset();
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
      for (int k = 1; k < 4; k++) begin
         repeat (2) @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1 || out_pc !== 32'h10 + k) begin
            n_fail++;
            $display("FAIL back_to_back: k=%0d valid=%0b pc=%h, expected 1 %h",
                     k, out_valid, out_pc, 32'h10 + k);
         end
      end
   endtask

   // Model walks the program in order from the current target; redirects restart it
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [15:0] w0, imm;
      logic [6:0]  opc;
      bit two, model_halted, hold;
      logic [15:0] h_instr, h_imm;
      logic [31:0] h_pc;
      int fires;
      mem.delete();
      for (int a = 32'h10; a < 32'h90; a++) begin
         mem[a] = 16'($urandom);
         if ($urandom_range(99, 0) < 3) mem[a] = 16'h0800;
      end
      lat_min = 0; lat_max = 3;
      out_ready = 1'b1;
      do_reset();
      exp_pc = 32'h10;
      model_halted = 1'b0;
      hold = 1'b0;
      fires = 0;
      h_instr = '0; h_imm = '0; h_pc = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         out_ready = ($urandom_range(9, 0) < 7);
         redirect = ($urandom_range(99, 0) < 4);
         redirect_pc = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFFE : $urandom_range(32'h8F, 32'h10);
         @(negedge clk);
         n_tests++;
         if (halted !== model_halted || (model_halted && (mem_req !== 1'b0 || out_valid !== 1'b0))) begin
            n_fail++;
            $display("FAIL rand_halt: cyc=%0d halted=%0b req=%0b valid=%0b, expected halted=%0b",
                     cyc, halted, mem_req, out_valid, model_halted);
         end
         if (hold) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_instr !== h_instr || out_imm !== h_imm || out_pc !== h_pc) begin
               n_fail++;
               $display("FAIL rand_hold: cyc=%0d valid=%0b instr=%h imm=%h pc=%h, expected 1 %h %h %h",
                        cyc, out_valid, out_instr, out_imm, out_pc, h_instr, h_imm, h_pc);
            end
         end
         hold = (out_valid === 1'b1) && !out_ready && !redirect;
         h_instr = out_instr; h_imm = out_imm; h_pc = out_pc;
         if (redirect) begin
            exp_pc = redirect_pc;
            model_halted = 1'b0;
         end else if (out_valid === 1'b1 && out_ready) begin
            w0 = rd(exp_pc);
            opc = w0[15:9];
            two = (opc == 7'd40) || ((opc >> 3) == 7'd7) || ((opc >> 3) == 7'd10) ||
                  ((opc >> 3) == 7'd11);
            imm = two ? rd(exp_pc + 1) : 16'h0;
            fires++;
            n_tests++;
            if (out_pc !== exp_pc || out_instr !== w0 || out_opcode !== opc || out_imm !== imm) begin
               n_fail++;
               $display("FAIL rand_issue: cyc=%0d pc=%h instr=%h opc=%h imm=%h, expected %h %h %h %h",
                        cyc, out_pc, out_instr, out_opcode, out_imm, exp_pc, w0, opc, imm);
            end
            exp_pc = exp_pc + (two ? 32'd2 : 32'd1);
            if ((opc >> 2) == 7'd1) model_halted = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      redirect = 1'b0;
      n_tests++;
      if (fires < 200) begin
         n_fail++;
         $display("FAIL rand_progress: fires=%0d, expected at least 200", fires);
      end
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      test_reset();
      test_nop();
      test_two_word();
      test_stall();
      test_redirect_kill();
      test_halt();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
